// File: rtl/ifetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, issues reads to the synchronous
// instruction memory, and hands words to decode through an output register plus skid buffer.
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {StRun, StHold, StFault} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        inflight_q, inflight_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        transfer;
    logic        issue;

    function automatic logic pc_bad(input logic [31:0] pc);
        return ({2'b00, pc[31:2]} >= IMEM_DEPTH) || (pc[1:0] != 2'b00);
    endfunction

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        out_valid_d   = out_valid_q;
        out_instr_d   = out_instr_q;
        out_pc_d      = out_pc_q;
        skid_valid_d  = skid_valid_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;
        transfer      = out_valid_q & id_ready;
        issue         = 1'b0;

        if (redirect_valid) begin
            // Everything queued or arriving belongs to the wrong path.
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            fetch_pc_d   = redirect_pc;
            state_d      = pc_bad(redirect_pc) ? StFault : StRun;
        end else begin
            if (!out_valid_q || transfer) begin
                if (skid_valid_q) begin
                    out_valid_d  = 1'b1;
                    out_instr_d  = skid_instr_q;
                    out_pc_d     = skid_pc_q;
                    skid_valid_d = inflight_q;
                    if (inflight_q) begin
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = inflight_pc_q;
                    end
                end else begin
                    out_valid_d = inflight_q;
                    if (inflight_q) begin
                        out_instr_d = imem_rdata;
                        out_pc_d    = inflight_pc_q;
                    end
                end
            end else if (inflight_q) begin
                skid_valid_d = 1'b1;
                skid_instr_d = imem_rdata;
                skid_pc_d    = inflight_pc_q;
            end

            // Issue only if the word can land without overflowing the skid buffer.
            issue = (state_q != StFault) && !skid_valid_d;
            if (issue) begin
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + 32'd4;
            end

            if (pc_bad(fetch_pc_d)) begin
                state_d = StFault;
            end else if (skid_valid_d) begin
                state_d = StHold;
            end else begin
                state_d = StRun;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StRun;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            out_valid_q   <= 1'b0;
            out_instr_q   <= '0;
            out_pc_q      <= '0;
            skid_valid_q  <= 1'b0;
            skid_instr_q  <= '0;
            skid_pc_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            out_valid_q   <= out_valid_d;
            out_instr_q   <= out_instr_d;
            out_pc_q      <= out_pc_d;
            skid_valid_q  <= skid_valid_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc_q     <= skid_pc_d;
        end
    end

    assign imem_addr   = (state_q == StFault) ? 32'd0 : {2'b00, fetch_pc_q[31:2]};
    assign if_valid    = out_valid_q;
    assign if_instr    = out_instr_q;
    assign if_pc       = out_pc_q;
    assign fetch_fault = (state_q == StFault);

endmodule
